// File: rtl/btn_press_decoder.sv
// Button press decoder: turns a debounced, synchronous button level into
// press / short-press / long-press / auto-repeat / release pulses, a held
// level and a modulo-256 press counter. All outputs are registered.
module btn_press_decoder #(
  parameter int LONG_CYCLES   = 16,
  parameter int REPEAT_CYCLES = 4,
  parameter int CNT_W         = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       filteredButton,
  output logic       pressPulse,
  output logic       shortPress,
  output logic       longPress,
  output logic       repeatPulse,
  output logic       releasePulse,
  output logic       held,
  output logic [7:0] pressCount
);

  typedef enum logic [1:0] {
    IDLE,
    PRESSED,
    LONG
  } state_t;

  // Terminal counts for the hold counter in each holding state.
  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             btn_prev_q, btn_prev_d;
  logic [7:0]       press_count_q, press_count_d;
  logic             press_pulse_q, press_pulse_d;
  logic             short_press_q, short_press_d;
  logic             long_press_q, long_press_d;
  logic             repeat_pulse_q, repeat_pulse_d;
  logic             release_pulse_q, release_pulse_d;
  logic             held_q, held_d;

  // Next-state and next-output logic for the press/hold FSM.
  always_comb begin
    // NOTE: every signal gets a default first so no path can leave one
    // unassigned, which would otherwise infer a latch.
    state_d         = state_q;
    cnt_d           = cnt_q;
    btn_prev_d      = filteredButton;
    press_count_d   = press_count_q;
    press_pulse_d   = 1'b0;
    short_press_d   = 1'b0;
    long_press_d    = 1'b0;
    repeat_pulse_d  = 1'b0;
    release_pulse_d = 1'b0;

    case (state_q)
      IDLE: begin
        // A press needs a fresh 0->1 edge; release and press never share an edge.
        if (filteredButton && !btn_prev_q) begin
          press_pulse_d = 1'b1;
          press_count_d = press_count_q + 8'd1;
          cnt_d         = '0;
          state_d       = PRESSED;
        end
      end
      PRESSED: begin
        if (filteredButton) begin
          if (cnt_q == LONG_LAST) begin
            long_press_d = 1'b1;
            cnt_d        = '0;
            state_d      = LONG;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          short_press_d   = 1'b1;
          release_pulse_d = 1'b1;
          cnt_d           = '0;
          state_d         = IDLE;
        end
      end
      LONG: begin
        if (filteredButton) begin
          if (cnt_q == REPEAT_LAST) begin
            repeat_pulse_d = 1'b1;
            cnt_d          = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          // Releasing a long hold is not a short press.
          release_pulse_d = 1'b1;
          cnt_d           = '0;
          state_d         = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    held_d = (state_d != IDLE);
  end

  // State, counter, edge-detect copy and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      btn_prev_q      <= 1'b0;
      press_count_q   <= 8'd0;
      press_pulse_q   <= 1'b0;
      short_press_q   <= 1'b0;
      long_press_q    <= 1'b0;
      repeat_pulse_q  <= 1'b0;
      release_pulse_q <= 1'b0;
      held_q          <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      btn_prev_q      <= btn_prev_d;
      press_count_q   <= press_count_d;
      press_pulse_q   <= press_pulse_d;
      short_press_q   <= short_press_d;
      long_press_q    <= long_press_d;
      repeat_pulse_q  <= repeat_pulse_d;
      release_pulse_q <= release_pulse_d;
      held_q          <= held_d;
    end
  end

  assign pressPulse   = press_pulse_q;
  assign shortPress   = short_press_q;
  assign longPress    = long_press_q;
  assign repeatPulse  = repeat_pulse_q;
  assign releasePulse = release_pulse_q;
  assign held         = held_q;
  assign pressCount   = press_count_q;

endmodule

// File: tb/tb_btn_press_decoder.sv
// Testbench for btn_press_decoder: directed button patterns, a duration-based
// behavioural model checked on every cycle, plus hand-computed event checks.
module tb_btn_press_decoder;

  localparam int LONG_CYCLES   = 16;
  localparam int REPEAT_CYCLES = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       filteredButton = 1'b0;
  logic       pressPulse, shortPress, longPress, repeatPulse, releasePulse, held;
  logic [7:0] pressCount;

  int n_checks = 0;
  int n_errors = 0;

  btn_press_decoder #(
    .LONG_CYCLES  (LONG_CYCLES),
    .REPEAT_CYCLES(REPEAT_CYCLES),
    .CNT_W        (16)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .filteredButton(filteredButton),
    .pressPulse    (pressPulse),
    .shortPress    (shortPress),
    .longPress     (longPress),
    .repeatPulse   (repeatPulse),
    .releasePulse  (releasePulse),
    .held          (held),
    .pressCount    (pressCount)
  );

  always #5 clock = ~clock;

  // Model state: button level last edge, whether a hold is in progress,
  // how many edges since the press edge, and the press count.
  logic m_prev;
  logic m_holding;
  int   m_len;
  int   m_count;
  logic e_press, e_short, e_long, e_repeat, e_release;
  bit   cmp_en = 1'b0;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic model_reset();
    m_prev = 1'b0; m_holding = 1'b0; m_len = 0; m_count = 0;
    e_press = 1'b0; e_short = 1'b0; e_long = 1'b0; e_repeat = 1'b0; e_release = 1'b0;
  endtask

  // Outputs follow from how long the button has been down since its press edge.
  task automatic model_edge(input logic b);
    e_press = 1'b0; e_short = 1'b0; e_long = 1'b0; e_repeat = 1'b0; e_release = 1'b0;
    if (!m_holding) begin
      if (b && !m_prev) begin
        e_press   = 1'b1;
        m_holding = 1'b1;
        m_len     = 0;
        m_count   = (m_count + 1) % 256;
      end
    end else if (b) begin
      m_len++;
      if (m_len == LONG_CYCLES) e_long = 1'b1;
      else if (m_len > LONG_CYCLES && (m_len - LONG_CYCLES) % REPEAT_CYCLES == 0)
        e_repeat = 1'b1;
    end else begin
      e_release = 1'b1;
      e_short   = (m_len < LONG_CYCLES);
      m_holding = 1'b0;
    end
    m_prev = b;
  endtask

  // Single compare process: every cycle out of reset, DUT vs model.
  always @(negedge clock) begin
    if (cmp_en && !reset) begin
      check("pressPulse",   int'(pressPulse),   int'(e_press));
      check("shortPress",   int'(shortPress),   int'(e_short));
      check("longPress",    int'(longPress),    int'(e_long));
      check("repeatPulse",  int'(repeatPulse),  int'(e_repeat));
      check("releasePulse", int'(releasePulse), int'(e_release));
      check("held",         int'(held),         int'(m_holding));
      check("pressCount",   int'(pressCount),   m_count);
    end
  end

  // Drive one sampled level: set input away from the edge, let one rising
  // edge sample it, advance the model, and return at the following negedge.
  task automatic step(input logic b);
    filteredButton = b;
    @(posedge clock);
    model_edge(b);
    @(negedge clock);
  endtask

  // Hold high for n_high edges (E0..E(n_high-1)), then low for one edge;
  // records the edge index of each DUT event for literal checks.
  int press_at, long_at, short_at, rel_at, rep_first, rep_n;
  task automatic run_hold(input int n_high);
    press_at = -1; long_at = -1; short_at = -1; rel_at = -1; rep_first = -1; rep_n = 0;
    for (int i = 0; i <= n_high; i++) begin
      step(i < n_high);
      if (pressPulse)   press_at = i;
      if (longPress)    long_at  = i;
      if (shortPress)   short_at = i;
      if (releasePulse) rel_at   = i;
      if (repeatPulse) begin
        if (rep_first < 0) rep_first = i;
        rep_n++;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    #1;
    // Reset forces outputs low without a clock edge.
    check("reset_held", int'(held), 0);
    check("reset_count", int'(pressCount), 0);
    check("reset_pulses", int'({pressPulse, shortPress, longPress, repeatPulse, releasePulse}), 0);
    @(negedge clock);
    #2 reset = 1'b0;
    cmp_en = 1'b1;
    step(1'b0);

    // Short press of three edges.
    run_hold(3);
    check("short3_press_at", press_at, 0);
    check("short3_short_at", short_at, 3);
    check("short3_rel_at", rel_at, 3);
    check("short3_long_at", long_at, -1);
    check("short3_count", int'(pressCount), 1);
    step(1'b0);

    // Sixteen edges high: one edge short of a long press.
    run_hold(16);
    check("short16_short_at", short_at, 16);
    check("short16_long_at", long_at, -1);
    step(1'b0);

    // Thirty edges high: long press, three repeats, release without short.
    run_hold(30);
    check("long30_long_at", long_at, 16);
    check("long30_rep_first", rep_first, 20);
    check("long30_rep_n", rep_n, 3);
    check("long30_rel_at", rel_at, 30);
    check("long30_short_at", short_at, -1);
    check("long30_count", int'(pressCount), 3);
    step(1'b0);

    // 1,0,1,0 on consecutive edges: two full presses.
    step(1'b1); check("tog_p1", int'(pressPulse), 1);
    step(1'b0); check("tog_r1", int'(shortPress & releasePulse), 1);
    step(1'b1); check("tog_p2", int'(pressPulse), 1);
    step(1'b0); check("tog_r2", int'(shortPress & releasePulse), 1);
    check("tog_count", int'(pressCount), 5);
    step(1'b0);

    // Reset in the middle of a long hold with the button kept high.
    for (int i = 0; i < 18; i++) step(1'b1);
    check("pre_reset_held", int'(held), 1);
    #2 reset = 1'b1;
    #1;
    check("midreset_held", int'(held), 0);
    check("midreset_count", int'(pressCount), 0);
    check("midreset_pulses", int'({pressPulse, shortPress, longPress, repeatPulse, releasePulse}), 0);
    model_reset();
    @(posedge clock);
    @(negedge clock);
    check("inreset_release", int'(releasePulse), 0);
    #2 reset = 1'b0;
    step(1'b1);
    check("post_reset_press", int'(pressPulse), 1);
    check("post_reset_count", int'(pressCount), 1);
    step(1'b0);

    // Count wrap: 254 more presses reach 255, the next one wraps to 0.
    for (int i = 0; i < 254; i++) begin
      step(1'b1);
      step(1'b0);
    end
    check("count_255", int'(pressCount), 255);
    step(1'b1);
    check("count_wrap", int'(pressCount), 0);
    step(1'b0);
    step(1'b0);

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/btn_press_decoder.md
BTN_PRESS_DECODER -- requirements
Module: btn_press_decoder

Interface
REQ-001 Parameter LONG_CYCLES, default 16: clock edges after the press edge at which a long press is declared; legal range >= 2.
REQ-002 Parameter REPEAT_CYCLES, default 4: auto-repeat period in clock edges once a long press is declared; legal range >= 1.
REQ-003 Parameter CNT_W, default 16: hold-counter width; LONG_CYCLES and REPEAT_CYCLES SHALL both be < 2^CNT_W.
REQ-004 clock  input  1  single system clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 filteredButton  input  1  debounced button level from BTN_FILTER; already synchronous to clock.
REQ-007 pressPulse  output  1  one-cycle pulse on each new press.
REQ-008 shortPress  output  1  one-cycle pulse on release before long-press threshold.
REQ-009 longPress  output  1  one-cycle pulse when hold reaches threshold.
REQ-010 repeatPulse  output  1  one-cycle pulse every REPEAT_CYCLES while long-held.
REQ-011 releasePulse  output  1  one-cycle pulse on every release.
REQ-012 held  output  1  level, high while the FSM is in PRESSED or LONG.
REQ-013 pressCount  output  8  number of presses since reset, modulo 256.

Function
REQ-014 All outputs SHALL be registered; each event SHALL appear in the cycle following the rising edge that samples it (latency 1 edge).
REQ-015 Edge detection SHALL use a registered copy btnPrev of filteredButton; a press edge is an edge sampling filteredButton=1 with btnPrev=0.
REQ-016 FSM states SHALL be IDLE, PRESSED and LONG; reset state SHALL be IDLE.
REQ-017 IDLE, press edge: pressPulse=1, pressCount+1 (255 wraps to 0), cnt=0, go to PRESSED.
REQ-018 PRESSED, filteredButton=1, cnt != LONG_CYCLES-1: cnt+1.
REQ-019 PRESSED, filteredButton=1, cnt == LONG_CYCLES-1: longPress=1, cnt=0, go to LONG.
REQ-020 PRESSED, filteredButton=0: shortPress=1, releasePulse=1, go to IDLE.
REQ-021 LONG, filteredButton=1, cnt == REPEAT_CYCLES-1: repeatPulse=1, cnt=0; otherwise cnt+1.
REQ-022 LONG, filteredButton=0: releasePulse=1, shortPress stays 0, go to IDLE.
REQ-023 Release and a new press can never share an edge; a 1,0,1 input pattern SHALL produce release at the 0-edge and a new press at the following 1-edge.
REQ-024 All pulse outputs SHALL be 0 in every cycle that has no event; shortPress and longPress SHALL never both be high in the same cycle.
REQ-025 The counter SHALL never exceed max(LONG_CYCLES, REPEAT_CYCLES)-1; no overflow is possible.

Reset
REQ-026 Asserting reset SHALL force, without waiting for a clock edge: state=IDLE, cnt=0, btnPrev=0, pressCount=0, and all pulse outputs and held to 0.
REQ-027 Reset asserted mid-hold (PRESSED or LONG) SHALL abort the hold with no shortPress, longPress or releasePulse.
REQ-028 If filteredButton=1 at the first edge after reset deasserts, that edge SHALL count as a press edge, because btnPrev=0.

Verification (LONG_CYCLES=16, REPEAT_CYCLES=4; E0 = first edge sampling 1)
REQ-029 Button high for E0..E2, low at E3 -> pressPulse after E0; shortPress and releasePulse after E3; no longPress; pressCount=1.
REQ-030 Button high for E0..E15, low at E16 -> shortPress after E16; longPress never asserts.
REQ-031 Button high for E0..E29, low at E30 -> longPress after E16; repeatPulse after E20, E24 and E28; releasePulse after E30; shortPress never asserts.
REQ-032 Button toggles 1,0,1,0 on consecutive edges -> pressPulse after each 1-edge; shortPress plus releasePulse after each 0-edge; pressCount=2.
REQ-033 256 short presses -> pressCount reads 255 after the 255th press and 0 after the 256th.
REQ-034 Reset pulsed at E18 of a long hold, button kept high -> outputs 0 immediately and no releasePulse; at the first edge after reset deasserts, pressPulse asserts and pressCount=1.
